// File: rtl/spi_slave_axis.sv
// SPI slave (any CPOL/CPHA, selectable bit order) bridging an oversampled SPI link
// to AXI-Stream TX/RX byte streams with a 1-deep pending RX stage and overrun flag.
module spi_slave_axis #(
   parameter bit         CLOCK_POLARITY_G = 1'b0,
   parameter bit         CLOCK_PHASE_G    = 1'b0,
   parameter bit         MSB_FIRST_G      = 1'b1,
   parameter logic [7:0] IDLE_BYTE_G      = 8'hFF
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       cs,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       busy,
   output logic       overrun
);

   logic [1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
   logic       sclk_prev_q, cs_prev_q;
   logic       sclk_s, mosi_s, cs_s;

   // cs synchronizer resets to "asserted" so a frame already running at reset
   // release never produces a falling edge and is ignored until cs goes high.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         sclk_sync_q <= {2{CLOCK_POLARITY_G}};
         sclk_prev_q <= CLOCK_POLARITY_G;
         mosi_sync_q <= '0;
         cs_sync_q   <= '0;
         cs_prev_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], sclk};
         sclk_prev_q <= sclk_sync_q[1];
         mosi_sync_q <= {mosi_sync_q[0], mosi};
         cs_sync_q   <= {cs_sync_q[0], cs};
         cs_prev_q   <= cs_sync_q[1];
      end
   end

   assign sclk_s = sclk_sync_q[1];
   assign mosi_s = mosi_sync_q[1];
   assign cs_s   = cs_sync_q[1];

   logic       selected_q, selected_d;
   logic       miso_q, miso_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       pend_valid_q, pend_valid_d, pend_last_q, pend_last_d;
   logic [7:0] pend_data_q, pend_data_d;
   logic       m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic [7:0] m_data_q, m_data_d;
   logic       overrun_q, overrun_d;

   logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
   logic       frame_start, frame_end, in_frame, sample_edge, shift_edge;
   logic       byte_done, tx_load, out_ready;
   logic [7:0] rx_next, tx_byte;

   function automatic logic first_bit(input logic [7:0] b);
      return MSB_FIRST_G ? b[7] : b[0];
   endfunction

   function automatic logic [7:0] rest_bits(input logic [7:0] b);
      return MSB_FIRST_G ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
   endfunction

   assign sclk_rise   = sclk_s & ~sclk_prev_q;
   assign sclk_fall   = ~sclk_s & sclk_prev_q;
   assign lead_edge   = CLOCK_POLARITY_G ? sclk_fall : sclk_rise;
   assign trail_edge  = CLOCK_POLARITY_G ? sclk_rise : sclk_fall;
   assign frame_start = cs_prev_q & ~cs_s;
   assign frame_end   = selected_q & cs_s;
   assign in_frame    = selected_q & ~cs_s;
   assign sample_edge = in_frame & (CLOCK_PHASE_G ? trail_edge : lead_edge);
   assign shift_edge  = in_frame & (CLOCK_PHASE_G ? lead_edge : trail_edge);
   assign rx_next     = MSB_FIRST_G ? {rx_q[6:0], mosi_s} : {mosi_s, rx_q[7:1]};
   assign byte_done   = sample_edge & (bit_cnt_q == 3'd7);
   assign tx_load     = frame_start | byte_done;
   assign tx_byte     = s_axis_tvalid ? s_axis_tdata : IDLE_BYTE_G;
   assign out_ready   = ~m_valid_q | m_axis_tready;

   always_comb begin
      selected_d   = selected_q;
      miso_d       = miso_q;
      tx_d         = tx_q;
      rx_d         = rx_q;
      bit_cnt_d    = bit_cnt_q;
      pend_valid_d = pend_valid_q;
      pend_last_d  = pend_last_q;
      pend_data_d  = pend_data_q;
      m_valid_d    = m_valid_q;
      m_last_d     = m_last_q;
      m_data_d     = m_data_q;
      overrun_d    = overrun_q;

      if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;

      // With CPHA=0 the first bit must already be on the wire at the first edge.
      if (frame_start) begin
         selected_d = 1'b1;
         bit_cnt_d  = 3'd0;
         overrun_d  = 1'b0;
         if (!CLOCK_PHASE_G) begin
            miso_d = first_bit(tx_byte);
            tx_d   = rest_bits(tx_byte);
         end else begin
            miso_d = 1'b0;
            tx_d   = tx_byte;
         end
      end

      if (frame_end) begin
         selected_d = 1'b0;
         miso_d     = 1'b0;
         if (pend_valid_q) pend_last_d = 1'b1;
      end

      if (shift_edge) begin
         miso_d = first_bit(tx_q);
         tx_d   = rest_bits(tx_q);
      end

      if (sample_edge) begin
         rx_d      = rx_next;
         bit_cnt_d = bit_cnt_q + 3'd1;
      end

      if (byte_done) begin
         tx_d = tx_byte;
         if (!pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_data_d  = rx_next;
            pend_last_d  = 1'b0;
         end else if (out_ready) begin
            m_valid_d   = 1'b1;
            m_data_d    = pend_data_q;
            m_last_d    = pend_last_q;
            pend_data_d = rx_next;
            pend_last_d = 1'b0;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (pend_valid_q && pend_last_q && out_ready) begin
         m_valid_d    = 1'b1;
         m_data_d     = pend_data_q;
         m_last_d     = 1'b1;
         pend_valid_d = 1'b0;
         pend_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         selected_q   <= 1'b0;
         miso_q       <= 1'b0;
         tx_q         <= '0;
         rx_q         <= '0;
         bit_cnt_q    <= '0;
         pend_valid_q <= 1'b0;
         pend_last_q  <= 1'b0;
         pend_data_q  <= '0;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         m_data_q     <= '0;
         overrun_q    <= 1'b0;
      end else begin
         selected_q   <= selected_d;
         miso_q       <= miso_d;
         tx_q         <= tx_d;
         rx_q         <= rx_d;
         bit_cnt_q    <= bit_cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_last_q  <= pend_last_d;
         pend_data_q  <= pend_data_d;
         m_valid_q    <= m_valid_d;
         m_last_q     <= m_last_d;
         m_data_q     <= m_data_d;
         overrun_q    <= overrun_d;
      end
   end

   assign s_axis_tready = tx_load & s_axis_tvalid;
   assign miso          = miso_q;
   assign miso_oe       = selected_q;
   assign busy          = selected_q;
   assign overrun       = overrun_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_spi_slave_axis.sv
// Drives a mode-0/MSB-first and a mode-3/LSB-first slave with the same frames
// and checks RX stream, bytes seen by the master, tready pulses and overrun.
module tb_spi_slave_axis;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cs;
   logic [1:0] sclk_w, mosi_w, miso_w, miso_oe_w;
   logic [1:0] s_tvalid, s_tready, m_tvalid, m_tready, m_tlast, busy_w, ovr_w;
   logic [7:0] s_tdata [2];
   logic [7:0] m_tdata [2];

   always #5 clk = ~clk;

   spi_slave_axis dut0 (
      .clk_in(clk), .rst_in(rst_n),
      .sclk(sclk_w[0]), .mosi(mosi_w[0]), .cs(cs),
      .miso(miso_w[0]), .miso_oe(miso_oe_w[0]),
      .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
      .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
      .m_axis_tlast(m_tlast[0]), .busy(busy_w[0]), .overrun(ovr_w[0])
   );

   spi_slave_axis #(
      .CLOCK_POLARITY_G(1'b1), .CLOCK_PHASE_G(1'b1), .MSB_FIRST_G(1'b0), .IDLE_BYTE_G(8'hFF)
   ) dut1 (
      .clk_in(clk), .rst_in(rst_n),
      .sclk(sclk_w[1]), .mosi(mosi_w[1]), .cs(cs),
      .miso(miso_w[1]), .miso_oe(miso_oe_w[1]),
      .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
      .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
      .m_axis_tlast(m_tlast[1]), .busy(busy_w[1]), .overrun(ovr_w[1])
   );

   int checks = 0;
   int errors = 0;

   function automatic logic [7:0] byte_of(input logic [31:0] v, input int i);
      case (i)
         0:       return v[31:24];
         1:       return v[23:16];
         2:       return v[15:8];
         default: return v[7:0];
      endcase
   endfunction

   // TX producer / RX consumer models
   logic [31:0] tx_vec;
   int          tx_n;
   int          tx_idx [2];
   int          trdy_cnt [2];
   int          rx_cnt [2];
   logic [7:0]  rx_data [2][4];
   logic        rx_last [2][4];
   logic        clr;

   always_comb begin
      for (int d = 0; d < 2; d++) begin
         s_tvalid[d] = (tx_idx[d] < tx_n);
         s_tdata[d]  = byte_of(tx_vec, tx_idx[d]);
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (clr) begin
            tx_idx[d]   <= 0;
            trdy_cnt[d] <= 0;
            rx_cnt[d]   <= 0;
         end else begin
            if (s_tready[d]) begin
               tx_idx[d]   <= tx_idx[d] + 1;
               trdy_cnt[d] <= trdy_cnt[d] + 1;
            end
            if (m_tvalid[d] && m_tready[d]) begin
               if (rx_cnt[d] < 4) begin
                  rx_data[d][rx_cnt[d]] <= m_tdata[d];
                  rx_last[d][rx_cnt[d]] <= m_tlast[d];
               end
               rx_cnt[d] <= rx_cnt[d] + 1;
            end
         end
      end
   end

   task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0h expected %0h", name, d, got, exp);
      end
   endtask

   // SPI master: both slaves sample on rising sclk; dut1 idles high and sees LSB first.
   logic [31:0] miso_got [2];

   task automatic spi_bits(input int nbits, input logic [31:0] data);
      int k, j;
      for (int b = 0; b < nbits; b++) begin
         k = b / 8;
         j = b % 8;
         sclk_w    = 2'b00;
         mosi_w[0] = data[31 - 8*k - j];
         mosi_w[1] = data[24 - 8*k + j];
         #80;
         sclk_w = 2'b11;
         miso_got[0][31 - 8*k - j] = miso_w[0];
         miso_got[1][24 - 8*k + j] = miso_w[1];
         #80;
      end
   endtask

   task automatic run_frame(input int nbits, input logic [31:0] data);
      miso_got[0] = '0;
      miso_got[1] = '0;
      cs = 1'b0;
      #160;
      spi_bits(nbits, data);
      sclk_w = 2'b10;
      #80;
      cs = 1'b1;
      #300;
   endtask

   task automatic clear_models();
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
   endtask

   typedef struct {
      int          nbits;
      logic [31:0] mosi;
      int          ntx;
      logic [31:0] tx;
      int          exp_n;
      logic [31:0] exp_rx;
      logic [3:0]  exp_last;
      int          nmiso;
      logic [31:0] exp_miso;
      int          exp_trdy;
   } vec_t;

   task automatic run_vec(input vec_t v, input int idx);
      m_tready = 2'b11;
      tx_vec   = v.tx;
      tx_n     = v.ntx;
      clear_models();
      run_frame(v.nbits, v.mosi);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("v%0d rx_cnt", idx), d, 32'(rx_cnt[d]), 32'(v.exp_n));
         for (int i = 0; i < v.exp_n; i++) begin
            chk($sformatf("v%0d rx_data%0d", idx, i), d, 32'(rx_data[d][i]), 32'(byte_of(v.exp_rx, i)));
            chk($sformatf("v%0d rx_last%0d", idx, i), d, 32'(rx_last[d][i]), 32'(v.exp_last[i]));
         end
         for (int i = 0; i < v.nmiso; i++)
            chk($sformatf("v%0d miso_byte%0d", idx, i), d, 32'(byte_of(miso_got[d], i)), 32'(byte_of(v.exp_miso, i)));
         chk($sformatf("v%0d tready_pulses", idx), d, 32'(trdy_cnt[d]), 32'(v.exp_trdy));
         chk($sformatf("v%0d overrun", idx), d, 32'(ovr_w[d]), 32'd0);
         chk($sformatf("v%0d busy_idle", idx), d, 32'(busy_w[d]), 32'd0);
         $display("vec %0d dut%0d: %0d bits, rx_cnt=%0d tready=%0d miso=%h", idx, d, v.nbits, rx_cnt[d], trdy_cnt[d], miso_got[d]);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk({tag, " miso"}, d, 32'(miso_w[d]), 32'd0);
         chk({tag, " miso_oe"}, d, 32'(miso_oe_w[d]), 32'd0);
         chk({tag, " busy"}, d, 32'(busy_w[d]), 32'd0);
         chk({tag, " overrun"}, d, 32'(ovr_w[d]), 32'd0);
         chk({tag, " s_tready"}, d, 32'(s_tready[d]), 32'd0);
         chk({tag, " m_tvalid"}, d, 32'(m_tvalid[d]), 32'd0);
         chk({tag, " m_tdata"}, d, 32'(m_tdata[d]), 32'd0);
         chk({tag, " m_tlast"}, d, 32'(m_tlast[d]), 32'd0);
      end
   endtask

   vec_t vecs [4];

   initial begin
      vecs[0] = '{24, 32'h37485900, 3, 32'hA1B2C300, 3, 32'h37485900, 4'b0100, 3, 32'hA1B2C300, 3};
      vecs[1] = '{16, 32'h12340000, 0, 32'h00000000, 2, 32'h12340000, 4'b0010, 2, 32'hFFFF0000, 0};
      vecs[2] = '{13, 32'hC5A00000, 1, 32'h5C000000, 1, 32'hC5000000, 4'b0001, 1, 32'h5C000000, 1};
      vecs[3] = '{ 8, 32'h81000000, 2, 32'h3C990000, 1, 32'h81000000, 4'b0001, 1, 32'h3C000000, 2};

      rst_n    = 1'b0;
      cs       = 1'b1;
      sclk_w   = 2'b10;
      mosi_w   = 2'b00;
      m_tready = 2'b11;
      tx_vec   = '0;
      tx_n     = 0;
      clr      = 1'b1;
      #23;
      chk_reset_outputs("por");
      rst_n = 1'b1;
      clear_models();
      #100;

      for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

      // Output stalled: 01 held, 02 pending, 03/04 dropped.
      m_tready = 2'b00;
      tx_n     = 0;
      clear_models();
      run_frame(32, 32'h01020304);
      for (int d = 0; d < 2; d++) begin
         chk("stall m_tvalid", d, 32'(m_tvalid[d]), 32'd1);
         chk("stall m_tdata", d, 32'(m_tdata[d]), 32'h01);
         chk("stall m_tlast", d, 32'(m_tlast[d]), 32'd0);
         chk("stall overrun", d, 32'(ovr_w[d]), 32'd1);
         chk("stall rx_cnt", d, 32'(rx_cnt[d]), 32'd0);
      end
      m_tready = 2'b11;
      #200;
      for (int d = 0; d < 2; d++) begin
         chk("drain rx_cnt", d, 32'(rx_cnt[d]), 32'd2);
         chk("drain data0", d, 32'(rx_data[d][0]), 32'h01);
         chk("drain last0", d, 32'(rx_last[d][0]), 32'd0);
         chk("drain data1", d, 32'(rx_data[d][1]), 32'h02);
         chk("drain last1", d, 32'(rx_last[d][1]), 32'd1);
         chk("drain overrun_sticky", d, 32'(ovr_w[d]), 32'd1);
         $display("stall frame dut%0d: rx_cnt=%0d overrun=%0d", d, rx_cnt[d], ovr_w[d]);
      end

      // Reset mid-byte, then the remainder of that frame must be ignored.
      clear_models();
      cs = 1'b0;
      #160;
      spi_bits(4, 32'h5A000000);
      rst_n = 1'b0;
      #30;
      chk_reset_outputs("midrst");
      #20 rst_n = 1'b1;
      #50;
      spi_bits(12, 32'hC3C30000);
      for (int d = 0; d < 2; d++) begin
         chk("ignored busy", d, 32'(busy_w[d]), 32'd0);
         chk("ignored miso_oe", d, 32'(miso_oe_w[d]), 32'd0);
      end
      sclk_w = 2'b10;
      #80;
      cs = 1'b1;
      #300;
      for (int d = 0; d < 2; d++) begin
         chk("ignored rx_cnt", d, 32'(rx_cnt[d]), 32'd0);
         $display("aborted frame dut%0d: rx_cnt=%0d", d, rx_cnt[d]);
      end
      run_vec('{8, 32'h5A000000, 0, 32'h00000000, 1, 32'h5A000000, 4'b0001, 1, 32'hFF000000, 0}, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
